sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_CYCLES, default 780, meaning clk_c1 cycles between refresh requests (7.8 us at 100 MHz).
REQ-002 Parameter BURST_LEN, default 256, meaning words per read/write burst and address increment per completed burst.
REQ-003 Parameter FRAME_WORDS, default 307200, meaning frame size in words; must be a multiple of BURST_LEN.
REQ-004 Parameter ADDR_W, default 22, meaning SDRAM word-address width.
REQ-005 clk_c1  in  1  100 MHz system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 init_done  in  1  SDRAM power-up initialisation complete, level.
REQ-008 wr_req  in  1  write requester (camera FIFO holds >= BURST_LEN words), level.
REQ-009 wr_ack  out  1  one-cycle pulse: write burst accepted by controller.
REQ-010 rd_req  in  1  read requester (display FIFO has >= BURST_LEN free), level.
REQ-011 rd_ack  out  1  one-cycle pulse: read burst accepted by controller.
REQ-012 cmd_valid  out  1  command presented to SDRAM controller.
REQ-013 cmd_type  out  2  00 refresh, 01 write, 10 read, 11 unused.
REQ-014 cmd_addr  out  ADDR_W  burst start address; 0 for refresh.
REQ-015 cmd_ready  in  1  controller accepts command this cycle.
REQ-016 cmd_done  in  1  one-cycle pulse: accepted command finished.
REQ-017 wr_frame_done, rd_frame_done  out  1 each  one-cycle pulse when respective address wraps.
REQ-018 ref_overrun  out  1  sticky: refresh deadline missed.

Function
REQ-019 States: WAIT_INIT, IDLE, ISSUE, BUSY; reset state WAIT_INIT.
REQ-020 WAIT_INIT -> IDLE on first cycle init_done=1; refresh timer starts from 0 that cycle.
REQ-021 Refresh timer counts 0..REFRESH_CYCLES-1 and wraps; on terminal count sets ref_pending.
REQ-022 Terminal count while ref_pending already set: ref_overrun set to 1, held until reset.
REQ-023 IDLE arbitration, priority: ref_pending > read/write; among rd_req and wr_req both high, grant the one not granted last (last_grant reset = write, so read wins first tie); single requester granted directly.
REQ-024 IDLE with a grant -> ISSUE next cycle; cmd_valid=1 with cmd_type/cmd_addr registered, held stable until cmd_ready.
REQ-025 ISSUE and cmd_ready=1: cmd_valid drops next cycle, state -> BUSY, matching wr_ack/rd_ack pulses the same cycle as acceptance, ref_pending cleared on refresh acceptance.
REQ-026 Latency: request seen in IDLE at cycle N -> cmd_valid at N+1 -> ack in the cycle cmd_ready is sampled high (earliest N+1).
REQ-027 BUSY -> IDLE on cmd_done; on write/read done, respective address += BURST_LEN.
REQ-028 Address reaching FRAME_WORDS wraps to 0 and pulses the respective frame_done in the same cycle as the update.
REQ-029 Refresh never preempts ISSUE or BUSY; it is served at the next IDLE decision.
REQ-030 cmd_done outside BUSY is ignored; requests dropping during ISSUE do not cancel the issued command.
REQ-031 Requests are ignored in WAIT_INIT; simultaneous terminal count and refresh acceptance leaves ref_pending=1 without overrun.
REQ-032 init_done falling in any state: next cycle state=WAIT_INIT, cmd_valid=0, ref_pending=0, timer=0, both addresses=0; ref_overrun kept.

Reset
REQ-033 rst_n=0 asynchronously forces: state WAIT_INIT, all outputs 0 (cmd_type=00, cmd_addr=0), addresses 0, timer 0, ref_pending 0, last_grant=write, ref_overrun 0.
REQ-034 Release of rst_n is synchronous in effect: first state change no earlier than first clk_c1 edge after release.

Verification
REQ-035 init_done=1, rd_req=wr_req=1, cmd_ready=1, cmd_done 5 cycles after each accept -> grants alternate read(addr 0), write(addr 0), read(256), write(256).
REQ-036 REFRESH_CYCLES=780, no requests, cmd_ready=1 -> cmd_type=00 accepted at 780-cycle intervals, ref_overrun stays 0.
REQ-037 Hold BUSY (no cmd_done) 1600 cycles -> ref_overrun=1 after second terminal count; after cmd_done refresh issued before pending rd_req.
REQ-038 FRAME_WORDS=1024, BURST_LEN=256, 4 write bursts -> wr_frame_done pulses once on 4th cmd_done, next write cmd_addr=0.
REQ-039 cmd_ready low 10 cycles in ISSUE -> cmd_valid, cmd_type, cmd_addr stable all 10 cycles, no ack until cmd_ready=1.
REQ-040 Drop init_done during BUSY, then rst_n=0 mid-ISSUE -> state WAIT_INIT, cmd_valid=0, addresses 0; after reset all outputs 0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Arbitrates SDRAM access between periodic refresh, a camera write
//   requester and a display read requester. Refresh has top priority;
//   when read and write both ask, they alternate. Each requester walks a
//   frame buffer in BURST_LEN steps and wraps at FRAME_WORDS.
//
// Ports
//   clk_c1          in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   init_done       in   SDRAM init complete (level); low restarts the arbiter
//   wr_req/rd_req   in   burst requests (level)
//   wr_ack/rd_ack   out  pulse when the burst command is accepted
//   cmd_valid       out  command presented to the controller
//   cmd_type        out  00 refresh, 01 write, 10 read
//   cmd_addr        out  burst start word address (0 for refresh)
//   cmd_ready       in   controller accepts the command this cycle
//   cmd_done        in   pulse when the accepted command has finished
//   wr_frame_done   out  pulse when the write address wraps
//   rd_frame_done   out  pulse when the read address wraps
//   ref_overrun     out  sticky: a refresh deadline was missed
module sdram_arbiter #(
    parameter int REFRESH_CYCLES = 780,
    parameter int BURST_LEN      = 256,
    parameter int FRAME_WORDS    = 307200,
    parameter int ADDR_W         = 22
) (
    input  logic              clk_c1,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              wr_req,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic              cmd_valid,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              wr_frame_done,
    output logic              rd_frame_done,
    output logic              ref_overrun
);

    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W:0]   BURST_INC = (ADDR_W+1)'(BURST_LEN);
    localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W+1)'(FRAME_WORDS);

    localparam logic [1:0] CMD_REF = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;

    typedef enum logic [1:0] {
        S_WAIT_INIT = 2'd0,
        S_IDLE      = 2'd1,
        S_ISSUE     = 2'd2,
        S_BUSY      = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic                r_ref_pending;
    logic                r_ref_overrun;
    logic                r_last_wr;      // 1: last read/write grant went to write
    logic                r_cmd_valid;
    logic [1:0]          r_cmd_type;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [ADDR_W-1:0]   r_rd_addr;

    logic                w_tc;
    logic                w_accept;
    logic                w_ref_accept;
    logic                w_done;
    logic                w_grant;
    logic [1:0]          w_grant_type;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic [ADDR_W:0]     w_wr_next;
    logic [ADDR_W:0]     w_rd_next;
    logic                w_wr_wrap;
    logic                w_rd_wrap;

    // Timer runs whenever init_done is high, so it starts at 0 in the
    // cycle WAIT_INIT sees init_done and is cleared whenever init is lost.
    assign w_tc         = init_done && (r_timer == TMR_LAST);
    assign w_accept     = (r_state == S_ISSUE) && cmd_ready;
    assign w_ref_accept = w_accept && (r_cmd_type == CMD_REF);
    // Losing init_done takes priority over a completion in the same cycle.
    assign w_done       = init_done && (r_state == S_BUSY) && cmd_done;

    assign w_wr_next = {1'b0, r_wr_addr} + BURST_INC;
    assign w_rd_next = {1'b0, r_rd_addr} + BURST_INC;
    assign w_wr_wrap = (w_wr_next >= FRAME_END);
    assign w_rd_wrap = (w_rd_next >= FRAME_END);

    always_ff @(posedge clk_c1 or negedge rst_n) begin
        if (!rst_n) r_state <= S_WAIT_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_type = CMD_REF;
        w_grant_addr = '0;
        case (r_state)
            S_WAIT_INIT: if (init_done) w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (r_ref_pending) begin
                    w_grant      = 1'b1;
                    w_grant_type = CMD_REF;
                end else if (rd_req && wr_req) begin
                    w_grant      = 1'b1;
                    w_grant_type = r_last_wr ? CMD_RD : CMD_WR;
                end else if (rd_req) begin
                    w_grant      = 1'b1;
                    w_grant_type = CMD_RD;
                end else if (wr_req) begin
                    w_grant      = 1'b1;
                    w_grant_type = CMD_WR;
                end
                if (w_grant_type == CMD_WR)      w_grant_addr = r_wr_addr;
                else if (w_grant_type == CMD_RD) w_grant_addr = r_rd_addr;
                if (w_grant) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: if (cmd_ready) w_state_nxt = S_BUSY;
            S_BUSY:  if (cmd_done)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_WAIT_INIT;
        endcase
        if (!init_done) begin
            w_state_nxt = S_WAIT_INIT;
            w_grant     = 1'b0;
        end
    end

    always_ff @(posedge clk_c1 or negedge rst_n) begin
        if (!rst_n) begin
            r_timer       <= '0;
            r_ref_pending <= 1'b0;
            r_ref_overrun <= 1'b0;
            r_last_wr     <= 1'b1;
            r_cmd_valid   <= 1'b0;
            r_cmd_type    <= CMD_REF;
            r_cmd_addr    <= '0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
        end else if (!init_done) begin
            // Abort everything in flight; only the overrun history survives.
            r_timer       <= '0;
            r_ref_pending <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_type    <= CMD_REF;
            r_cmd_addr    <= '0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
        end else begin
            r_timer <= w_tc ? '0 : r_timer + 1'b1;

            // A new deadline arriving while a refresh is accepted re-arms
            // pending; it is not a miss since the previous one was just served.
            if (w_tc)              r_ref_pending <= 1'b1;
            else if (w_ref_accept) r_ref_pending <= 1'b0;

            if (w_tc && r_ref_pending && !w_ref_accept) r_ref_overrun <= 1'b1;

            if (w_grant) begin
                r_cmd_valid <= 1'b1;
                r_cmd_type  <= w_grant_type;
                r_cmd_addr  <= w_grant_addr;
                if (w_grant_type != CMD_REF) r_last_wr <= (w_grant_type == CMD_WR);
            end else if (w_accept) begin
                r_cmd_valid <= 1'b0;
            end

            if (w_done && r_cmd_type == CMD_WR)
                r_wr_addr <= w_wr_wrap ? '0 : w_wr_next[ADDR_W-1:0];
            if (w_done && r_cmd_type == CMD_RD)
                r_rd_addr <= w_rd_wrap ? '0 : w_rd_next[ADDR_W-1:0];
        end
    end

    always_comb begin
        cmd_valid     = r_cmd_valid;
        cmd_type      = r_cmd_type;
        cmd_addr      = r_cmd_addr;
        ref_overrun   = r_ref_overrun;
        wr_ack        = w_accept && (r_cmd_type == CMD_WR);
        rd_ack        = w_accept && (r_cmd_type == CMD_RD);
        wr_frame_done = w_done && (r_cmd_type == CMD_WR) && w_wr_wrap;
        rd_frame_done = w_done && (r_cmd_type == CMD_RD) && w_rd_wrap;
    end

endmodule
